// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense sequencer.
package vend_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VEND_PULSE,
      S_VEND_WAIT,
      S_PAY_PULSE,
      S_PAY_WAIT,
      S_DONE,
      S_FAULT
   } vend_state_e;

   localparam int NUM_DEN = 5;

   localparam int LANE_COLD_DRINK    = 0;
   localparam int LANE_DAIRY_MILK    = 1;
   localparam int LANE_BISCUITS      = 2;
   localparam int LANE_RED_BULL      = 3;
   localparam int LANE_IMPORTED_CHOC = 4;

   localparam int DEN_100 = 0;
   localparam int DEN_50  = 1;
   localparam int DEN_20  = 2;
   localparam int DEN_10  = 3;
   localparam int DEN_5   = 4;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_ITEM_TMO = 2'b01;
   localparam logic [1:0] FC_NOTE_TMO = 2'b10;

endpackage

// File: rtl/vend_dispense_sequencer_if.sv
// Bundle between the transaction controller, the sequencer and the motor/hopper drivers.
interface vend_dispense_sequencer_if
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS = 5,
   parameter int CNT_W     = 4,
   parameter int NOTE_W    = 8
);
   logic                        req_valid;
   logic                        req_ready;
   logic [NUM_ITEMS*CNT_W-1:0]  req_counts;
   logic [NUM_DEN*NOTE_W-1:0]   req_notes;
   logic [NUM_ITEMS-1:0]        motor_sel;
   logic                        motor_on;
   logic                        drop_ack;
   logic [NUM_DEN-1:0]          hopper_sel;
   logic                        hopper_pulse;
   logic                        hopper_ack;
   logic                        clear_fault;
   logic                        busy;
   logic                        done;
   logic                        fault;
   logic [1:0]                  fault_code;

   modport master (
      output req_valid, req_counts, req_notes, drop_ack, hopper_ack, clear_fault,
      input  req_ready, motor_sel, motor_on, hopper_sel, hopper_pulse, busy, done, fault, fault_code
   );

   modport slave (
      input  req_valid, req_counts, req_notes, drop_ack, hopper_ack, clear_fault,
      output req_ready, motor_sel, motor_on, hopper_sel, hopper_pulse, busy, done, fault, fault_code
   );
endinterface

// File: rtl/vend_lane_picker.sv
// Priority encoder over remaining counters: one-hot pick of the next lane to serve.
module vend_lane_picker #(
   parameter int N         = 5,
   parameter int W         = 4,
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic [N-1:0][W-1:0] i_cnt,
   output logic [N-1:0]        o_sel,
   output logic                o_any
);
   always_comb begin
      o_sel = '0;
      // Later writes win, so scan toward the preferred end last.
      if (LOW_FIRST) begin
         for (int i = N - 1; i >= 0; i--)
            if (i_cnt[i] != '0) o_sel = N'(1) << i;
      end else begin
         for (int i = 0; i < N; i++)
            if (i_cnt[i] != '0) o_sel = N'(1) << i;
      end
      o_any = |o_sel;
   end
endmodule

// File: rtl/vend_dispense_sequencer.sv
// Pays out one vending batch: items one at a time, then notes, each confirmed by a sensor ack.
module vend_dispense_sequencer
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS   = 5,
   parameter int CNT_W       = 4,
   parameter int NOTE_W      = 8,
   parameter int PULSE_CYC   = 3,
   parameter int TIMEOUT_CYC = 16
) (
   input logic                  clk,
   input logic                  rst,
   vend_dispense_sequencer_if.slave bus
);
   localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC + 1) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   vend_state_e                       r_state, w_state_nxt;
   logic [NUM_ITEMS-1:0][CNT_W-1:0]   r_items, w_items_nxt;
   logic [NUM_DEN-1:0][NOTE_W-1:0]    r_notes, w_notes_nxt;
   logic [NUM_ITEMS-1:0]              r_item_sel, w_item_oh;
   logic [NUM_DEN-1:0]                r_note_sel, w_note_oh;
   logic                              w_item_any, w_note_any;
   logic [PW-1:0]                     r_pulse;
   logic [TW-1:0]                     r_tmo;
   logic [1:0]                        r_fcode, w_fcode_nxt;
   logic                              r_motor_on, r_hopper_pulse, r_busy, r_req_ready, r_done, r_fault;
   logic                              w_tmo_exp;

   // Pickers see the post-update counters so a lane choice is ready on the same edge.
   vend_lane_picker #(.N(NUM_ITEMS), .W(CNT_W),  .LOW_FIRST(1'b1)) u_item_pick (
      .i_cnt(w_items_nxt), .o_sel(w_item_oh), .o_any(w_item_any));
   vend_lane_picker #(.N(NUM_DEN),   .W(NOTE_W), .LOW_FIRST(1'b1)) u_note_pick (
      .i_cnt(w_notes_nxt), .o_sel(w_note_oh), .o_any(w_note_any));

   assign w_tmo_exp = (r_tmo == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      w_items_nxt = r_items;
      w_notes_nxt = r_notes;
      if (r_state == S_IDLE && bus.req_valid) begin
         w_items_nxt = bus.req_counts;
         w_notes_nxt = bus.req_notes;
      end else if (r_state == S_VEND_WAIT && bus.drop_ack) begin
         for (int i = 0; i < NUM_ITEMS; i++)
            if (r_item_sel[i] && r_items[i] != '0) w_items_nxt[i] = r_items[i] - CNT_W'(1);
      end else if (r_state == S_PAY_WAIT && bus.hopper_ack) begin
         for (int i = 0; i < NUM_DEN; i++)
            if (r_note_sel[i] && r_notes[i] != '0) w_notes_nxt[i] = r_notes[i] - NOTE_W'(1);
      end else if (r_state == S_FAULT && bus.clear_fault) begin
         w_items_nxt = '0;
         w_notes_nxt = '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fcode_nxt = r_fcode;
      case (r_state)
         S_IDLE:
            if (bus.req_valid)
               w_state_nxt = w_item_any ? S_VEND_PULSE : (w_note_any ? S_PAY_PULSE : S_DONE);
         S_VEND_PULSE:
            if (r_pulse == PW'(PULSE_CYC - 1)) w_state_nxt = S_VEND_WAIT;
         S_VEND_WAIT:
            if (bus.drop_ack)
               w_state_nxt = w_item_any ? S_VEND_PULSE : (w_note_any ? S_PAY_PULSE : S_DONE);
            else if (w_tmo_exp) begin
               w_state_nxt = S_FAULT;
               w_fcode_nxt = FC_ITEM_TMO;
            end
         S_PAY_PULSE:
            w_state_nxt = S_PAY_WAIT;
         S_PAY_WAIT:
            if (bus.hopper_ack)
               w_state_nxt = w_note_any ? S_PAY_PULSE : S_DONE;
            else if (w_tmo_exp) begin
               w_state_nxt = S_FAULT;
               w_fcode_nxt = FC_NOTE_TMO;
            end
         S_DONE:
            w_state_nxt = S_IDLE;
         S_FAULT:
            if (bus.clear_fault) begin
               w_state_nxt = S_IDLE;
               w_fcode_nxt = FC_NONE;
            end
         default:
            w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_items        <= '0;
         r_notes        <= '0;
         r_item_sel     <= '0;
         r_note_sel     <= '0;
         r_pulse        <= '0;
         r_tmo          <= '0;
         r_fcode        <= FC_NONE;
         r_motor_on     <= 1'b0;
         r_hopper_pulse <= 1'b0;
         r_busy         <= 1'b0;
         r_req_ready    <= 1'b1;
         r_done         <= 1'b0;
         r_fault        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_items <= w_items_nxt;
         r_notes <= w_notes_nxt;
         r_fcode <= w_fcode_nxt;
         r_pulse <= (r_state == S_VEND_PULSE && w_state_nxt == S_VEND_PULSE) ? r_pulse + PW'(1) : '0;
         r_tmo   <= ((r_state == S_VEND_WAIT || r_state == S_PAY_WAIT) && w_state_nxt == r_state)
                    ? r_tmo + TW'(1) : '0;

         // Lane select is captured on entry to a pulse and held through its wait.
         if (w_state_nxt == S_VEND_PULSE && r_state != S_VEND_PULSE)
            r_item_sel <= w_item_oh;
         else if (w_state_nxt != S_VEND_PULSE && w_state_nxt != S_VEND_WAIT)
            r_item_sel <= '0;
         if (w_state_nxt == S_PAY_PULSE)
            r_note_sel <= w_note_oh;
         else if (w_state_nxt != S_PAY_WAIT)
            r_note_sel <= '0;

         r_motor_on     <= (w_state_nxt == S_VEND_PULSE);
         r_hopper_pulse <= (w_state_nxt == S_PAY_PULSE);
         r_busy         <= (w_state_nxt != S_IDLE);
         r_req_ready    <= (w_state_nxt == S_IDLE);
         r_done         <= (w_state_nxt == S_DONE);
         r_fault        <= (w_state_nxt == S_FAULT);
      end
   end

   assign bus.req_ready    = r_req_ready;
   assign bus.motor_sel    = r_item_sel;
   assign bus.motor_on     = r_motor_on;
   assign bus.hopper_sel   = r_note_sel;
   assign bus.hopper_pulse = r_hopper_pulse;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.fault        = r_fault;
   assign bus.fault_code   = r_fcode;
endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Directed plus randomized bench; expected payout order is built as a flat actuation list.
module tb_vend_dispense_sequencer;
   import vend_pkg::*;

   localparam int NI = 5;
   localparam int CW = 4;
   localparam int NW = 8;
   localparam int PC = 3;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vend_dispense_sequencer_if #(.NUM_ITEMS(NI), .CNT_W(CW), .NOTE_W(NW)) bus_if ();

   vend_dispense_sequencer #(
      .NUM_ITEMS(NI), .CNT_W(CW), .NOTE_W(NW), .PULSE_CYC(PC), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   int n_asrt = 0;
   int n_fail = 0;
   int it [NI];
   int nt [5];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_req();
      bus_if.req_valid = 1'b1;
      for (int i = 0; i < NI; i++) bus_if.req_counts[i*CW +: CW] = CW'(it[i]);
      for (int i = 0; i < 5; i++)  bus_if.req_notes[i*NW +: NW]  = NW'(nt[i]);
      tick();
      bus_if.req_valid = 1'b0;
   endtask

   // idly/ndly < 0 selects a random ack delay in 0..TO-1 per actuation.
   task automatic run_batch(input int idly, input int ndly, input bit spur);
      int q_kind[$];
      int q_lane[$];
      int d;
      logic [31:0] oh;
      for (int i = 0; i < NI; i++) for (int k = 0; k < it[i]; k++) begin q_kind.push_back(0); q_lane.push_back(i); end
      for (int i = 0; i < 5; i++)  for (int k = 0; k < nt[i]; k++) begin q_kind.push_back(1); q_lane.push_back(i); end
      chk("idle_ready", 32'(bus_if.req_ready), 1);
      if (spur) begin
         bus_if.drop_ack = 1'b1; tick(); bus_if.drop_ack = 1'b0;
         chk("idle_after_spur_ready", 32'(bus_if.req_ready), 1);
         chk("idle_after_spur_motor", 32'(bus_if.motor_on), 0);
      end
      send_req();
      chk("ready_low_after_accept", 32'(bus_if.req_ready), 0);
      chk("busy_after_accept", 32'(bus_if.busy), 1);
      for (int n = 0; n < q_kind.size(); n++) begin
         oh = 32'(1) << q_lane[n];
         if (q_kind[n] == 0) begin
            d = (idly < 0) ? int'($urandom_range(TO - 1, 0)) : idly;
            for (int p = 0; p < PC; p++) begin
               chk("motor_on_pulse", 32'(bus_if.motor_on), 1);
               chk("motor_sel_pulse", 32'(bus_if.motor_sel), oh);
               chk("hopper_quiet_vend", 32'(bus_if.hopper_pulse), 0);
               if (spur) bus_if.drop_ack = 1'b1;
               tick();
            end
            bus_if.drop_ack = 1'b0;
            for (int w = 0; w < d; w++) begin
               chk("motor_off_wait", 32'(bus_if.motor_on), 0);
               chk("motor_sel_wait", 32'(bus_if.motor_sel), oh);
               chk("no_fault_wait", 32'(bus_if.fault), 0);
               tick();
            end
            chk("motor_off_ack", 32'(bus_if.motor_on), 0);
            chk("motor_sel_ack", 32'(bus_if.motor_sel), oh);
            bus_if.drop_ack = 1'b1; tick(); bus_if.drop_ack = 1'b0;
         end else begin
            d = (ndly < 0) ? int'($urandom_range(TO - 1, 0)) : ndly;
            chk("hopper_pulse_on", 32'(bus_if.hopper_pulse), 1);
            chk("hopper_sel_pulse", 32'(bus_if.hopper_sel), oh);
            chk("motor_quiet_pay", 32'(bus_if.motor_on), 0);
            chk("motor_sel_quiet_pay", 32'(bus_if.motor_sel), 0);
            tick();
            for (int w = 0; w < d; w++) begin
               chk("hopper_pulse_single", 32'(bus_if.hopper_pulse), 0);
               chk("hopper_sel_wait", 32'(bus_if.hopper_sel), oh);
               chk("no_fault_pay", 32'(bus_if.fault), 0);
               tick();
            end
            chk("hopper_pulse_ack", 32'(bus_if.hopper_pulse), 0);
            bus_if.hopper_ack = 1'b1; tick(); bus_if.hopper_ack = 1'b0;
         end
      end
      chk("done_pulse", 32'(bus_if.done), 1);
      chk("busy_in_done", 32'(bus_if.busy), 1);
      chk("motor_off_done", 32'(bus_if.motor_on), 0);
      chk("hopper_off_done", 32'(bus_if.hopper_pulse), 0);
      chk("fault_clear_done", 32'(bus_if.fault), 0);
      tick();
      chk("done_single", 32'(bus_if.done), 0);
      chk("busy_falls", 32'(bus_if.busy), 0);
      chk("ready_back", 32'(bus_if.req_ready), 1);
   endtask

   // Drives one lane with no ack and expects the timeout fault after TO wait cycles.
   task automatic run_fault(input bit is_note, input int lane);
      logic [31:0] code;
      for (int i = 0; i < NI; i++) it[i] = 0;
      for (int i = 0; i < 5; i++)  nt[i] = 0;
      if (is_note) nt[lane] = 1; else it[lane] = 1;
      code = is_note ? 32'(FC_NOTE_TMO) : 32'(FC_ITEM_TMO);
      send_req();
      if (is_note) begin
         chk("tmo_hopper_pulse", 32'(bus_if.hopper_pulse), 1);
         tick();
      end else begin
         for (int p = 0; p < PC; p++) begin
            chk("tmo_motor_on", 32'(bus_if.motor_on), 1);
            tick();
         end
         chk("tmo_motor_fell", 32'(bus_if.motor_on), 0);
      end
      for (int w = 0; w < TO; w++) begin
         chk("tmo_no_fault_early", 32'(bus_if.fault), 0);
         tick();
      end
      for (int r = 0; r < 3; r++) begin
         chk("tmo_fault", 32'(bus_if.fault), 1);
         chk("tmo_code", 32'(bus_if.fault_code), code);
         chk("tmo_ready_low", 32'(bus_if.req_ready), 0);
         chk("tmo_busy", 32'(bus_if.busy), 1);
         chk("tmo_drives_off", {30'd0, bus_if.motor_on, bus_if.hopper_pulse}, 0);
         chk("tmo_sels_off", 32'({bus_if.motor_sel, bus_if.hopper_sel}), 0);
         bus_if.drop_ack = 1'b1; bus_if.hopper_ack = 1'b1;
         tick();
         bus_if.drop_ack = 1'b0; bus_if.hopper_ack = 1'b0;
      end
      bus_if.clear_fault = 1'b1; tick(); bus_if.clear_fault = 1'b0;
      chk("clr_fault", 32'(bus_if.fault), 0);
      chk("clr_code", 32'(bus_if.fault_code), 0);
      chk("clr_ready", 32'(bus_if.req_ready), 1);
      chk("clr_busy", 32'(bus_if.busy), 0);
   endtask

   initial begin
      bus_if.req_valid   = 1'b0;
      bus_if.req_counts  = '0;
      bus_if.req_notes   = '0;
      bus_if.drop_ack    = 1'b0;
      bus_if.hopper_ack  = 1'b0;
      bus_if.clear_fault = 1'b0;
      tick(); tick();
      chk("rst_ready", 32'(bus_if.req_ready), 1);
      chk("rst_busy", 32'(bus_if.busy), 0);
      chk("rst_done", 32'(bus_if.done), 0);
      chk("rst_fault", 32'(bus_if.fault), 0);
      chk("rst_code", 32'(bus_if.fault_code), 0);
      chk("rst_motor", {bus_if.motor_on, bus_if.hopper_pulse}, 0);
      chk("rst_sels", 32'({bus_if.motor_sel, bus_if.hopper_sel}), 0);
      rst = 1'b1;
      tick();

      it = '{2, 0, 1, 0, 0}; nt = '{0, 0, 0, 1, 1};
      run_batch(2, 1, 1'b0);

      it = '{0, 0, 0, 0, 0}; nt = '{0, 0, 0, 0, 0};
      run_batch(0, 0, 1'b0);

      run_fault(1'b0, LANE_COLD_DRINK);

      it = '{0, 0, 0, 0, 0}; nt = '{1, 0, 0, 0, 0};
      run_batch(0, TO - 1, 1'b0);

      it = '{0, 0, 0, 0, 1}; nt = '{0, 0, 0, 0, 0};
      run_batch(TO - 1, 0, 1'b0);

      run_fault(1'b1, DEN_20);

      it = '{0, 0, 1, 0, 0}; nt = '{0, 0, 0, 0, 0};
      run_batch(3, 0, 1'b1);

      // Async reset in the middle of a motor pulse.
      it = '{0, 2, 0, 0, 0}; nt = '{0, 0, 0, 0, 0};
      send_req();
      tick();
      chk("pre_rst_motor_on", 32'(bus_if.motor_on), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_motor_off", 32'(bus_if.motor_on), 0);
      chk("async_rst_sel", 32'(bus_if.motor_sel), 0);
      chk("async_rst_ready", 32'(bus_if.req_ready), 1);
      chk("async_rst_busy", 32'(bus_if.busy), 0);
      tick();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post_rst_idle_motor", 32'(bus_if.motor_on), 0);
         chk("post_rst_idle_ready", 32'(bus_if.req_ready), 1);
      end
      it = '{0, 0, 0, 0, 0}; nt = '{0, 0, 0, 0, 2};
      run_batch(0, 0, 1'b0);

      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < NI; i++) it[i] = int'($urandom_range(3, 0));
         for (int i = 0; i < 5; i++)  nt[i] = int'($urandom_range(3, 0));
         run_batch(-1, -1, 1'($urandom_range(1, 0)));
      end

      it = '{15, 15, 15, 15, 15}; nt = '{255, 255, 255, 255, 255};
      run_batch(0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
